token_sequencer: RTL and testbench

TOKEN_SEQUENCER -- requirements
Module: token_sequencer

---
 rtl/token_sequencer.sv | 133 +++++++++++++
 tb/tb_token_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/token_sequencer.sv
// Keypad-to-calculator token sequencer: accumulates decimal digits and emits number/operator tokens.
// Optional TOKSEQ_ECHO_EN adds disp_value, which echoes the operand being entered or the last number sent.
module token_sequencer #(
  parameter int MAX_DIGITS   = 9,
  parameter int GUARD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        calc_ready,
  output logic        calc_strobe,
  output logic [31:0] calc_token,
  output logic        busy,
  output logic        key_dropped
`ifdef TOKSEQ_ECHO_EN
  ,
  output logic [31:0] disp_value
`endif
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEND_NUM = 3'd1;
  localparam logic [2:0] WAIT_NUM = 3'd2;
  localparam logic [2:0] SEND_OP  = 3'd3;
  localparam logic [2:0] WAIT_OP  = 3'd4;

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1) + 1;

  logic [2:0]    r_state;
  logic [31:0]   r_acc;
  logic [DW-1:0] r_dcnt;
  logic [3:0]    r_op;
  logic [31:0]   r_token;
  logic [GW-1:0] r_guard;

  logic          w_is_digit;
  logic          w_is_clr;
  logic          w_send;
  logic          w_guard_done;
  logic [31:0]   w_num_token;
  logic [31:0]   w_op_token;
  logic [31:0]   w_new_token;

  assign w_is_digit   = (key_code <= 4'd9);
  assign w_is_clr     = (key_code == 4'hF);
  assign w_send       = ((r_state == SEND_NUM) || (r_state == SEND_OP)) && calc_ready;
  assign w_guard_done = (r_guard >= GW'(GUARD_CYCLES));
  assign w_num_token  = {1'b0, r_acc[30:0]};
  assign w_op_token   = {28'h8000000, r_op};
  assign w_new_token  = (r_state == SEND_NUM) ? w_num_token : w_op_token;

  // The strobe is combinational in the SEND state so it never overlaps a WAIT
  // state; the token register then holds the value until the next strobe.
  assign calc_strobe = w_send;
  assign calc_token  = w_send ? w_new_token : r_token;
  assign busy        = (r_state != IDLE);
  assign key_dropped = key_valid && busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= 32'd0;
      r_dcnt  <= '0;
      r_op    <= 4'd0;
      r_token <= 32'd0;
      r_guard <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            if (w_is_digit) begin
              if (r_dcnt != DW'(MAX_DIGITS)) begin
                r_acc  <= r_acc * 32'd10 + {28'd0, key_code};
                r_dcnt <= r_dcnt + 1'b1;
              end
            end else if (w_is_clr) begin
              r_acc   <= 32'd0;
              r_dcnt  <= '0;
              r_op    <= key_code;
              r_state <= SEND_OP;
            end else begin
              r_op    <= key_code;
              r_state <= (r_dcnt != '0) ? SEND_NUM : SEND_OP;
            end
          end
        end
        SEND_NUM: begin
          if (calc_ready) begin
            r_token <= w_num_token;
            r_acc   <= 32'd0;
            r_dcnt  <= '0;
            r_guard <= GW'(1);
            r_state <= WAIT_NUM;
          end
        end
        SEND_OP: begin
          if (calc_ready) begin
            r_token <= w_op_token;
            r_guard <= GW'(1);
            r_state <= WAIT_OP;
          end
        end
        WAIT_NUM, WAIT_OP: begin
          // The guard counter includes the current cycle, so exit happens no
          // earlier than the GUARD_CYCLES-th WAIT cycle.
          if (w_guard_done) begin
            if (calc_ready) r_state <= (r_state == WAIT_NUM) ? SEND_OP : IDLE;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TOKSEQ_ECHO_EN
  logic [31:0] r_disp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_disp <= 32'd0;
    end else if ((r_state == SEND_NUM) && calc_ready) begin
      r_disp <= w_num_token;
    end
  end

  assign disp_value = (r_dcnt != '0) ? r_acc : r_disp;
`endif

endmodule

// File: tb/tb_token_sequencer.sv
// Directed self-checking bench for token_sequencer: inputs change 1ns after posedge, outputs sampled on negedge.
module tb_token_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        calc_ready = 1'b1;
  logic        calc_strobe;
  logic [31:0] calc_token;
  logic        busy;
  logic        key_dropped;
`ifdef TOKSEQ_ECHO_EN
  logic [31:0] disp_value;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int drop_cnt = 0;
  logic [31:0] tok_q[$];
  int          stamp_q[$];
  logic [31:0] exp_q[$];

  token_sequencer #(.MAX_DIGITS(9), .GUARD_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .calc_ready (calc_ready),
    .calc_strobe(calc_strobe),
    .calc_token (calc_token),
    .busy       (busy),
    .key_dropped(key_dropped)
`ifdef TOKSEQ_ECHO_EN
    ,
    .disp_value (disp_value)
`endif
  );

  always #5 clk = ~clk;

  // Strobe/drop monitor
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (calc_strobe === 1'b1) begin
      tok_q.push_back(calc_token);
      stamp_q.push_back(cyc);
    end
    if (key_dropped === 1'b1) drop_cnt = drop_cnt + 1;
  end

  task automatic press(input logic [3:0] c);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_logs();
    tok_q.delete();
    stamp_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1;
    total++; if (calc_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%0b exp=0", calc_strobe); end
    total++; if (calc_token !== 32'd0) begin bad++; $display("FAIL reset_token got=%h exp=0", calc_token); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (key_dropped !== 1'b0) begin bad++; $display("FAIL reset_drop got=%0b exp=0", key_dropped); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    clear_logs();
    calc_ready = 1'b1;
    press(4'd1); press(4'd8); press(4'hA);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_timeout1 got=busy exp=idle"); end
    press(4'd9); press(4'hE);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_timeout2 got=busy exp=idle"); end
    exp_q = '{32'd18, 32'h8000000A, 32'd9, 32'h8000000E};
    total++;
    if (tok_q.size() != exp_q.size()) begin
      bad++; $display("FAIL basic_count got=%0d exp=%0d", tok_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (tok_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_tok%0d got=%h exp=%h", i, tok_q[i], exp_q[i]); end
      end
      for (int i = 1; i < stamp_q.size(); i++) begin
        total++; if (stamp_q[i] - stamp_q[i-1] < 3) begin bad++; $display("FAIL basic_space%0d got=%0d exp>=3", i, stamp_q[i] - stamp_q[i-1]); end
      end
    end
  endtask

  task automatic test_ready_low();
    bit ok;
    clear_logs();
    calc_ready = 1'b0;
    press(4'd7); press(4'hB);
    repeat (10) @(posedge clk);
    #1;
    total++; if (tok_q.size() != 0) begin bad++; $display("FAIL stall_nostrobe got=%0d exp=0", tok_q.size()); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%0b exp=1", busy); end
    calc_ready = 1'b1;
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_timeout got=busy exp=idle"); end
    exp_q = '{32'd7, 32'h8000000B};
    total++;
    if (tok_q.size() != exp_q.size()) begin
      bad++; $display("FAIL stall_count got=%0d exp=%0d", tok_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (tok_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_tok%0d got=%h exp=%h", i, tok_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_max_digits();
    bit ok;
    int d0;
    clear_logs();
    d0 = drop_cnt;
    for (int i = 0; i < 10; i++) press(4'd1);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL max_busy got=%0b exp=0", busy); end
    total++; if (tok_q.size() != 0) begin bad++; $display("FAIL max_notoken got=%0d exp=0", tok_q.size()); end
    total++; if (drop_cnt != d0) begin bad++; $display("FAIL max_nodrop got=%0d exp=%0d", drop_cnt, d0); end
`ifdef TOKSEQ_ECHO_EN
    total++; if (disp_value !== 32'd111111111) begin bad++; $display("FAIL max_disp got=%0d exp=111111111", disp_value); end
`endif
    press(4'hE);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL max_timeout got=busy exp=idle"); end
    exp_q = '{32'd111111111, 32'h8000000E};
    total++;
    if (tok_q.size() != exp_q.size()) begin
      bad++; $display("FAIL max_count got=%0d exp=%0d", tok_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (tok_q[i] !== exp_q[i]) begin bad++; $display("FAIL max_tok%0d got=%h exp=%h", i, tok_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_clr();
    bit ok;
    clear_logs();
    press(4'd4); press(4'd5); press(4'hF);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL clr_timeout got=busy exp=idle"); end
    // A following 2,E proves acc restarted from zero: tokens 2 and E, not 452.
    press(4'd2); press(4'hE);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL clr_timeout2 got=busy exp=idle"); end
    exp_q = '{32'h8000000F, 32'd2, 32'h8000000E};
    total++;
    if (tok_q.size() != exp_q.size()) begin
      bad++; $display("FAIL clr_count got=%0d exp=%0d", tok_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (tok_q[i] !== exp_q[i]) begin bad++; $display("FAIL clr_tok%0d got=%h exp=%h", i, tok_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_drop();
    bit ok;
    int d0;
    clear_logs();
    d0 = drop_cnt;
    calc_ready = 1'b1;
    press(4'hA);
    @(posedge clk); #1;
    calc_ready = 1'b0;
    press(4'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy%0d got=%0b exp=1", i, busy); end
    end
    total++; if (drop_cnt - d0 != 1) begin bad++; $display("FAIL drop_count got=%0d exp=1", drop_cnt - d0); end
    calc_ready = 1'b1;
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL drop_timeout got=busy exp=idle"); end
    press(4'hE);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL drop_timeout2 got=busy exp=idle"); end
    exp_q = '{32'h8000000A, 32'h8000000E};
    total++;
    if (tok_q.size() != exp_q.size()) begin
      bad++; $display("FAIL drop_tokcount got=%0d exp=%0d", tok_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (tok_q[i] !== exp_q[i]) begin bad++; $display("FAIL drop_tok%0d got=%h exp=%h", i, tok_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    calc_ready = 1'b1;
    press(4'd5); press(4'hA);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (calc_strobe !== 1'b0) begin bad++; $display("FAIL rmid_strobe got=%0b exp=0", calc_strobe); end
    total++; if (calc_token !== 32'd0) begin bad++; $display("FAIL rmid_token got=%h exp=0", calc_token); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    exp_q = '{32'd5};
    total++;
    if (tok_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rmid_count got=%0d exp=%0d", tok_q.size(), exp_q.size());
    end else begin
      total++; if (tok_q[0] !== exp_q[0]) begin bad++; $display("FAIL rmid_tok got=%h exp=%h", tok_q[0], exp_q[0]); end
    end
    clear_logs();
    press(4'd2); press(4'hE);
    wait_idle(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rmid_timeout got=busy exp=idle"); end
    exp_q = '{32'd2, 32'h8000000E};
    total++;
    if (tok_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rmid_count2 got=%0d exp=%0d", tok_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (tok_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmid_tok%0d got=%h exp=%h", i, tok_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_low();
    test_max_digits();
    test_clr();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
